// File: rtl/control_unit_pkg.sv
// Shared definitions for the ALUSystem instruction sequencer: state codes,
// opcodes and the select/function encodings the datapath expects.
package control_unit_pkg;

    localparam int SC_WIDTH = 3;

    typedef enum logic [SC_WIDTH-1:0] {
        ST_INIT    = 3'd0,
        ST_FETCH_L = 3'd1,
        ST_FETCH_H = 3'd2,
        ST_EXEC1   = 3'd3,
        ST_EXEC2   = 3'd4,
        ST_HALT    = 3'd5
    } state_t;

    localparam logic [3:0] OP_AND = 4'h0;
    localparam logic [3:0] OP_OR  = 4'h1;
    localparam logic [3:0] OP_NOT = 4'h2;
    localparam logic [3:0] OP_ADD = 4'h3;
    localparam logic [3:0] OP_SUB = 4'h4;
    localparam logic [3:0] OP_LSL = 4'h5;
    localparam logic [3:0] OP_LSR = 4'h6;
    localparam logic [3:0] OP_INC = 4'h7;
    localparam logic [3:0] OP_DEC = 4'h8;
    localparam logic [3:0] OP_BRA = 4'h9;
    localparam logic [3:0] OP_BEQ = 4'hA;
    localparam logic [3:0] OP_BNE = 4'hB;
    localparam logic [3:0] OP_LDI = 4'hC;
    localparam logic [3:0] OP_LD  = 4'hD;
    localparam logic [3:0] OP_ST  = 4'hE;
    localparam logic [3:0] OP_HLT = 4'hF;

    localparam logic [3:0] ALU_PASS_A = 4'b0000;
    localparam logic [3:0] ALU_NOT    = 4'b0010;
    localparam logic [3:0] ALU_ADD    = 4'b0100;
    localparam logic [3:0] ALU_SUB    = 4'b0101;
    localparam logic [3:0] ALU_AND    = 4'b0111;
    localparam logic [3:0] ALU_OR     = 4'b1000;
    localparam logic [3:0] ALU_LSL    = 4'b1011;
    localparam logic [3:0] ALU_LSR    = 4'b1100;

    localparam logic [1:0] FUN_CLR  = 2'b00;
    localparam logic [1:0] FUN_LOAD = 2'b01;
    localparam logic [1:0] FUN_DEC  = 2'b10;
    localparam logic [1:0] FUN_INC  = 2'b11;

    localparam logic [1:0] MUXA_ALU = 2'b00;
    localparam logic [1:0] MUXA_MEM = 2'b01;
    localparam logic [1:0] MUXA_IMM = 2'b10;
    localparam logic [1:0] MUXB_IMM = 2'b10;

    localparam logic [1:0] ARF_OUT_AR = 2'b00;
    localparam logic [1:0] ARF_OUT_PC = 2'b11;
    localparam logic [3:0] ARF_SEL_PC = 4'b0001;
    localparam logic [3:0] ARF_SEL_AR = 4'b1000;

    // Register field code 00..11 addresses R1..R4.
    function automatic logic [3:0] reg_rsel(input logic [1:0] code);
        return 4'b1000 >> code;
    endfunction

    function automatic logic [2:0] reg_outsel(input logic [1:0] code);
        return {1'b1, code};
    endfunction

endpackage

// File: rtl/control_unit_if.sv
// Control/status bundle between the sequencer (master) and the ALUSystem datapath (slave).
interface control_unit_if;
    logic [15:0] IROut;
    logic [3:0]  ALUOutFlag;
    logic [1:0]  ARF_OutASel, ARF_OutBSel, ARF_FunSel, RF_FunSel, IR_Funsel, MuxASel, MuxBSel;
    logic [3:0]  ALU_FunSel, RF_RSel, RF_TSel, ARF_RSel;
    logic [2:0]  RF_OutASel, RF_OutBSel;
    logic        Mem_WR, Mem_CS, IR_Enable, IR_LH, MuxCSel;
    logic [2:0]  SeqState;
    logic        Halted;

    modport master (
        input  IROut, ALUOutFlag,
        output ARF_OutASel, ARF_OutBSel, ARF_FunSel, RF_FunSel, IR_Funsel, MuxASel, MuxBSel,
        output ALU_FunSel, RF_RSel, RF_TSel, ARF_RSel, RF_OutASel, RF_OutBSel,
        output Mem_WR, Mem_CS, IR_Enable, IR_LH, MuxCSel, SeqState, Halted
    );

    modport slave (
        output IROut, ALUOutFlag,
        input  ARF_OutASel, ARF_OutBSel, ARF_FunSel, RF_FunSel, IR_Funsel, MuxASel, MuxBSel,
        input  ALU_FunSel, RF_RSel, RF_TSel, ARF_RSel, RF_OutASel, RF_OutBSel,
        input  Mem_WR, Mem_CS, IR_Enable, IR_LH, MuxCSel, SeqState, Halted
    );
endinterface

// File: rtl/control_unit_decoder.sv
// Combinational decode of {state, IR, latched flags} into every datapath control.
module control_unit_decoder
    import control_unit_pkg::*;
(
    input  state_t                state,
    input  logic [3:0]            flg,
    control_unit_if.master        bus
);
    logic [3:0] op;
    logic [1:0] dst, s1, s2;
    logic       z_flag;
    logic       branch_taken;

    assign op     = bus.IROut[15:12];
    assign dst    = bus.IROut[11:10];
    assign s1     = bus.IROut[9:8];
    assign s2     = bus.IROut[7:6];
    assign z_flag = flg[3];

    always_comb begin
        unique case (op)
            OP_BRA:  branch_taken = 1'b1;
            OP_BEQ:  branch_taken = z_flag;
            OP_BNE:  branch_taken = !z_flag;
            default: branch_taken = 1'b0;
        endcase
    end

    always_comb begin
        // Idle baseline: memory deselected, nothing written, PC on ARF out B.
        bus.ARF_OutASel = 2'b00;
        bus.ARF_OutBSel = ARF_OUT_PC;
        bus.ARF_FunSel  = 2'b00;
        bus.ARF_RSel    = 4'b0000;
        bus.RF_FunSel   = 2'b00;
        bus.RF_RSel     = 4'b0000;
        bus.RF_TSel     = 4'b0000;
        bus.RF_OutASel  = 3'b000;
        bus.RF_OutBSel  = 3'b000;
        bus.IR_Funsel   = 2'b00;
        bus.IR_Enable   = 1'b0;
        bus.IR_LH       = 1'b0;
        bus.MuxASel     = 2'b00;
        bus.MuxBSel     = 2'b00;
        bus.MuxCSel     = 1'b0;
        bus.ALU_FunSel  = 4'b0000;
        bus.Mem_CS      = 1'b1;
        bus.Mem_WR      = 1'b0;
        bus.SeqState    = state;
        bus.Halted      = (state == ST_HALT);

        unique case (state)
            ST_INIT: begin
                bus.ARF_RSel   = 4'b1111;
                bus.ARF_FunSel = FUN_CLR;
                bus.RF_RSel    = 4'b1111;
                bus.RF_TSel    = 4'b1111;
                bus.RF_FunSel  = FUN_CLR;
                bus.IR_Enable  = 1'b1;
                bus.IR_Funsel  = FUN_CLR;
            end
            ST_FETCH_L, ST_FETCH_H: begin
                bus.Mem_CS     = 1'b0;
                bus.IR_Enable  = 1'b1;
                bus.IR_Funsel  = FUN_LOAD;
                bus.IR_LH      = (state == ST_FETCH_H);
                bus.ARF_RSel   = ARF_SEL_PC;
                bus.ARF_FunSel = FUN_INC;
            end
            ST_EXEC1: begin
                unique case (op)
                    OP_AND, OP_OR, OP_NOT, OP_ADD, OP_SUB, OP_LSL, OP_LSR: begin
                        unique case (op)
                            OP_AND:  bus.ALU_FunSel = ALU_AND;
                            OP_OR:   bus.ALU_FunSel = ALU_OR;
                            OP_NOT:  bus.ALU_FunSel = ALU_NOT;
                            OP_ADD:  bus.ALU_FunSel = ALU_ADD;
                            OP_SUB:  bus.ALU_FunSel = ALU_SUB;
                            OP_LSL:  bus.ALU_FunSel = ALU_LSL;
                            default: bus.ALU_FunSel = ALU_LSR;
                        endcase
                        bus.RF_OutASel = reg_outsel(s1);
                        bus.RF_OutBSel = reg_outsel(s2);
                        bus.MuxCSel    = 1'b0;
                        bus.MuxASel    = MUXA_ALU;
                        bus.RF_RSel    = reg_rsel(dst);
                        bus.RF_FunSel  = FUN_LOAD;
                    end
                    OP_INC, OP_DEC: begin
                        bus.RF_RSel   = reg_rsel(dst);
                        bus.RF_FunSel = (op == OP_INC) ? FUN_INC : FUN_DEC;
                    end
                    OP_BRA, OP_BEQ, OP_BNE: begin
                        if (branch_taken) begin
                            bus.MuxBSel    = MUXB_IMM;
                            bus.ARF_RSel   = ARF_SEL_PC;
                            bus.ARF_FunSel = FUN_LOAD;
                        end
                    end
                    OP_LDI: begin
                        bus.MuxASel   = MUXA_IMM;
                        bus.RF_RSel   = reg_rsel(dst);
                        bus.RF_FunSel = FUN_LOAD;
                    end
                    OP_LD, OP_ST: begin
                        bus.MuxBSel    = MUXB_IMM;
                        bus.ARF_RSel   = ARF_SEL_AR;
                        bus.ARF_FunSel = FUN_LOAD;
                    end
                    default: ;
                endcase
            end
            ST_EXEC2: begin
                if (op == OP_LD) begin
                    bus.ARF_OutBSel = ARF_OUT_AR;
                    bus.Mem_CS      = 1'b0;
                    bus.MuxASel     = MUXA_MEM;
                    bus.RF_RSel     = reg_rsel(dst);
                    bus.RF_FunSel   = FUN_LOAD;
                end else if (op == OP_ST) begin
                    bus.RF_OutASel  = reg_outsel(dst);
                    bus.MuxCSel     = 1'b0;
                    bus.ALU_FunSel  = ALU_PASS_A;
                    bus.ARF_OutBSel = ARF_OUT_AR;
                    bus.Mem_CS      = 1'b0;
                    bus.Mem_WR      = 1'b1;
                end
            end
            default: ;
        endcase
    end
endmodule

// File: rtl/control_unit.sv
// ALUSystem instruction sequencer: two-byte fetch, 1-2 cycle execute, latched
// branch flags. All datapath controls are decoded from state, IR and flags.
module control_unit
    import control_unit_pkg::*;
(
    input  logic           Clock,
    input  logic           Reset,
    control_unit_if.master bus
);
    state_t     state, state_next;
    logic [3:0] flg;
    logic       flg_en;
    logic [1:0] flg_funsel;
    logic [3:0] op;

    assign op = bus.IROut[15:12];

    always_ff @(posedge Clock) begin
        if (Reset) state <= ST_INIT;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        unique case (state)
            ST_INIT:    state_next = ST_FETCH_L;
            ST_FETCH_L: state_next = ST_FETCH_H;
            ST_FETCH_H: state_next = ST_EXEC1;
            ST_EXEC1: begin
                if (op == OP_LD || op == OP_ST) state_next = ST_EXEC2;
                else if (op == OP_HLT)          state_next = ST_HALT;
                else                            state_next = ST_FETCH_L;
            end
            ST_EXEC2:   state_next = ST_FETCH_L;
            ST_HALT:    state_next = ST_HALT;
            default:    state_next = ST_INIT;
        endcase
    end

    // Flags are captured only by ALU ops, so branches and INC/DEC see the last ALU result.
    assign flg_en     = (state == ST_INIT) || (state == ST_EXEC1 && op <= OP_LSR);
    assign flg_funsel = (state == ST_INIT) ? FUN_CLR : FUN_LOAD;

    always_ff @(posedge Clock) begin
        if (Reset) begin
            flg <= 4'b0000;
        end else if (flg_en) begin
            if (flg_funsel == FUN_CLR) flg <= 4'b0000;
            else                       flg <= bus.ALUOutFlag;
        end
    end

    control_unit_decoder u_decoder (
        .state (state),
        .flg   (flg),
        .bus   (bus)
    );
endmodule
